// File: rtl/ccd_pkg.sv
// Shared types and default line geometry for the CCD capture path.
package ccd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DUMMY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_TRAIL  = 2'd3
  } ccd_state_e;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_LEAD_DUMMY  = 32;
  localparam int DEF_ACTIVE_PIX  = 3648;
  localparam int DEF_TRAIL_DUMMY = 14;
  localparam int DEF_FIFO_DEPTH  = 16;

  // Dark estimate averages the last 16 leading dummies (shift by 4).
  localparam int DARK_SAMPLES = 16;
  localparam int DARK_SHIFT   = 4;
  localparam int CNT_W        = 16;

endpackage

// File: rtl/ccd_sample_fifo.sv
// Synchronous show-ahead FIFO: head entry lives in an output register,
// the rest in a small array; a full FIFO still accepts a push when popped.
module ccd_sample_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_vld;
  logic [WIDTH-1:0] r_data;

  logic w_pop, w_push, w_full, w_mem_empty, w_load, w_bypass, w_mem_wr, w_mem_rd;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = r_vld & i_rd_en;
  assign w_push      = i_wr_en & (~w_full | w_pop);
  // Array holds everything except the head entry.
  assign w_mem_empty = (r_count <= CW'(1));
  assign w_load      = ~r_vld | w_pop;
  assign w_bypass    = w_load & w_mem_empty & w_push;
  assign w_mem_wr    = w_push & ~w_bypass;
  assign w_mem_rd    = w_load & ~w_mem_empty;

  always_ff @(posedge clk) begin
    if (w_mem_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_mem_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_mem_rd) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_vld    <= 1'b1;
      end else if (w_bypass) begin
        r_data <= i_wr_data;
        r_vld  <= 1'b1;
      end else if (w_pop) begin
        r_vld <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_data;
  assign o_full  = w_full;
  assign o_empty = ~r_vld;

endmodule

// File: rtl/ccd_pixel_capture.sv
// Linear CCD line capture: tracks dummy/active/trail pixels, estimates the
// dark level from leading dummies and buffers black-corrected active samples.
module ccd_pixel_capture
  import ccd_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEAD_DUMMY  = DEF_LEAD_DUMMY,
  parameter int ACTIVE_PIX  = DEF_ACTIVE_PIX,
  parameter int TRAIL_DUMMY = DEF_TRAIL_DUMMY,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SH,
  input  logic              pixel_ready,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic [DATA_W-1:0] black_level,
  output logic              busy,
  output logic              line_done,
  output logic              overflow,
  output logic              aborted
);

  localparam int AW = DATA_W + DARK_SHIFT;
  localparam int FW = DATA_W + 2;

  ccd_state_e r_state, w_state_nxt;

  logic              r_sh_d, r_pr_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [AW-1:0]     r_acc;
  logic [DATA_W-1:0] r_black;
  logic              r_smp_vld, r_smp_first, r_smp_last;
  logic [DATA_W-1:0] r_smp_data;
  logic              r_overflow, r_line_done, r_aborted;

  logic              w_sh_rise, w_pr_rise, w_pix;
  logic              w_lead_end, w_act_end, w_trail_end, w_in_dark;
  logic              w_dark_smp, w_act_smp, w_black_load;
  logic [AW-1:0]     w_acc_sum, w_acc_next;
  logic [DATA_W-1:0] w_corr;
  logic              w_fifo_full, w_fifo_empty, w_fifo_pop;
  logic [FW-1:0]     w_fifo_rd;

  assign w_sh_rise   = SH & ~r_sh_d;
  assign w_pr_rise   = pixel_ready & ~r_pr_d;
  // A line restart owns the cycle; a coincident pixel edge is dropped.
  assign w_pix       = w_pr_rise & ~w_sh_rise;
  assign w_lead_end  = (r_cnt == CNT_W'(LEAD_DUMMY - 1));
  assign w_act_end   = (r_cnt == CNT_W'(ACTIVE_PIX - 1));
  assign w_trail_end = (r_cnt == CNT_W'(TRAIL_DUMMY - 1));
  assign w_in_dark   = (r_cnt >= CNT_W'(LEAD_DUMMY - DARK_SAMPLES));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_sh_rise) begin
      w_state_nxt = ST_DUMMY;
    end else if (w_pr_rise) begin
      unique case (r_state)
        ST_DUMMY:  if (w_lead_end)  w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: if (w_act_end)   w_state_nxt = ST_TRAIL;
        ST_TRAIL:  if (w_trail_end) w_state_nxt = ST_IDLE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Output / qualifier logic
  always_comb begin
    busy         = (r_state != ST_IDLE);
    w_dark_smp   = w_pix & (r_state == ST_DUMMY) & w_in_dark;
    w_black_load = w_pix & (r_state == ST_DUMMY) & w_lead_end;
    w_act_smp    = w_pix & (r_state == ST_ACTIVE);
  end

  assign w_acc_sum  = r_acc + AW'(adc_data);
  assign w_acc_next = w_dark_smp ? w_acc_sum : r_acc;
  assign w_corr     = (adc_data > r_black) ? (adc_data - r_black) : '0;
  assign w_fifo_pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_d      <= 1'b0;
      r_pr_d      <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_black     <= '0;
      r_smp_vld   <= 1'b0;
      r_smp_first <= 1'b0;
      r_smp_last  <= 1'b0;
      r_smp_data  <= '0;
      r_overflow  <= 1'b0;
      r_line_done <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_sh_d      <= SH;
      r_pr_d      <= pixel_ready;
      r_line_done <= (r_state == ST_TRAIL) & (w_state_nxt == ST_IDLE);
      r_aborted   <= w_sh_rise & (r_state != ST_IDLE);

      if (w_sh_rise)
        r_cnt <= '0;
      else if (w_pr_rise && r_state != ST_IDLE)
        r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);

      if (w_sh_rise)       r_acc <= '0;
      else if (w_dark_smp) r_acc <= w_acc_sum;

      if (w_black_load) r_black <= w_acc_next[AW-1:DARK_SHIFT];

      r_smp_vld <= w_act_smp;
      if (w_act_smp) begin
        r_smp_data  <= w_corr;
        r_smp_first <= (r_cnt == '0);
        r_smp_last  <= w_act_end;
      end

      // A drop in the same cycle as a restart still marks the new line.
      if (r_smp_vld && w_fifo_full && !w_fifo_pop) r_overflow <= 1'b1;
      else if (w_sh_rise)                            r_overflow <= 1'b0;
    end
  end

  ccd_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_smp_vld),
    .i_wr_data ({r_smp_first, r_smp_last, r_smp_data}),
    .i_rd_en   (out_ready),
    .o_data    (w_fifo_rd),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign out_valid   = ~w_fifo_empty;
  assign out_first   = w_fifo_rd[FW-1];
  assign out_last    = w_fifo_rd[FW-2];
  assign out_data    = w_fifo_rd[DATA_W-1:0];
  assign black_level = r_black;
  assign overflow    = r_overflow;
  assign line_done   = r_line_done;
  assign aborted     = r_aborted;

endmodule

// File: tb/tb_ccd_pixel_capture.sv
// Directed bench for ccd_pixel_capture at default geometry (32/3648/14, depth 16).
module tb_ccd_pixel_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SH = 1'b0;
  logic        pixel_ready = 1'b0;
  logic [11:0] adc_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_first, out_last, busy, line_done, overflow, aborted;
  logic [11:0] out_data, black_level;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_abort = 0;
  logic [11:0] q_data[$];
  logic        q_first[$];
  logic        q_last[$];

  ccd_pixel_capture dut (
    .clk(clk), .rst(rst), .SH(SH), .pixel_ready(pixel_ready), .adc_data(adc_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .black_level(black_level),
    .busy(busy), .line_done(line_done), .overflow(overflow), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Record accepted outputs and event pulses mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_first.push_back(out_first);
      q_last.push_back(out_last);
    end
    if (line_done) n_done++;
    if (aborted)   n_abort++;
  end

  task automatic clear_q();
    q_data.delete(); q_first.delete(); q_last.delete();
  endtask

  task automatic pix(input logic [11:0] v);
    @(posedge clk); #1 adc_data = v; pixel_ready = 1'b1;
    @(posedge clk); #1 pixel_ready = 1'b0;
  endtask

  task automatic pixels(input int n, input logic [11:0] v);
    for (int i = 0; i < n; i++) pix(v);
  endtask

  task automatic sh_pulse();
    @(posedge clk); #1 SH = 1'b1;
    @(posedge clk); #1 SH = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_first, out_last, busy, line_done, overflow, aborted} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 0000000",
               {out_valid, out_first, out_last, busy, line_done, overflow, aborted});
    end
    n_cmp++;
    if (out_data !== 12'd0) begin
      n_bad++; $display("FAIL reset_out_data got %0d want 0", out_data);
    end
    n_cmp++;
    if (black_level !== 12'd0) begin
      n_bad++; $display("FAIL reset_black got %0d want 0", black_level);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int bad, nf, nl;
    clear_q(); n_done = 0; out_ready = 1'b1;
    sh_pulse();
    pixels(32, 12'd100);
    n_cmp++;
    if (black_level !== 12'd100) begin
      n_bad++; $display("FAIL nom_black got %0d want 100", black_level);
    end
    pixels(3648, 12'd600);
    pixels(14, 12'd100);
    repeat (10) @(posedge clk); #1;
    n_cmp++;
    if (q_data.size() !== 3648) begin
      n_bad++; $display("FAIL nom_count got %0d want 3648", q_data.size());
    end
    bad = 0; nf = 0; nl = 0;
    foreach (q_data[i]) begin
      if (q_data[i] !== 12'd500) bad++;
      if (q_first[i]) nf++;
      if (q_last[i])  nl++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL nom_data got %0d wrong samples want 0", bad);
    end
    n_cmp++;
    if (!(nf == 1 && q_first.size() > 0 && q_first[0] === 1'b1)) begin
      n_bad++; $display("FAIL nom_first got %0d tags want 1 at index 0", nf);
    end
    n_cmp++;
    if (!(nl == 1 && q_last.size() == 3648 && q_last[3647] === 1'b1)) begin
      n_bad++; $display("FAIL nom_last got %0d tags want 1 at index 3647", nl);
    end
    n_cmp++;
    if (n_done !== 1) begin
      n_bad++; $display("FAIL nom_line_done got %0d want 1", n_done);
    end
    n_cmp++;
    if ({busy, overflow} !== 2'b00) begin
      n_bad++; $display("FAIL nom_idle got busy/ovf %b want 00", {busy, overflow});
    end
  endtask

  task automatic test_underflow();
    int bad;
    clear_q(); out_ready = 1'b1;
    sh_pulse();
    pixels(32, 12'd100);
    pixels(3648, 12'd50);
    pixels(14, 12'd100);
    repeat (10) @(posedge clk); #1;
    bad = 0;
    foreach (q_data[i]) if (q_data[i] !== 12'd0) bad++;
    n_cmp++;
    if (q_data.size() !== 3648 || bad !== 0) begin
      n_bad++;
      $display("FAIL clamp got %0d samples %0d nonzero want 3648 samples 0 nonzero",
               q_data.size(), bad);
    end
  endtask

  task automatic test_overflow();
    int bad;
    clear_q(); out_ready = 1'b0;
    sh_pulse();
    pixels(32, 12'd100);
    for (int i = 0; i < 3648; i++) begin
      pix(12'(300 + (i % 50)));
      if (i == 100) begin
        n_cmp++;
        if (out_data !== 12'd200 || out_first !== 1'b1) begin
          n_bad++; $display("FAIL ovf_hold_mid got %0d/%b want 200/1", out_data, out_first);
        end
      end
    end
    pixels(14, 12'd100);
    repeat (5) @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, out_first, overflow} !== 3'b111 || out_data !== 12'd200) begin
      n_bad++;
      $display("FAIL ovf_hold_end got v/f/ovf %b data %0d want 111 data 200",
               {out_valid, out_first, overflow}, out_data);
    end
    out_ready = 1'b1;
    repeat (20) @(posedge clk); #1;
    bad = 0;
    foreach (q_data[i]) if (q_data[i] !== 12'(200 + i)) bad++;
    n_cmp++;
    if (q_data.size() !== 16 || bad !== 0) begin
      n_bad++;
      $display("FAIL ovf_drain got %0d entries %0d wrong want 16 entries 0 wrong",
               q_data.size(), bad);
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow);
    end
  endtask

  task automatic test_abort();
    int bad;
    clear_q(); n_done = 0; n_abort = 0; out_ready = 1'b1;
    sh_pulse();
    pixels(32, 12'd100);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL abort_ovf_clear got %b want 0", overflow);
    end
    pixels(40, 12'd150);
    sh_pulse();
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (n_abort !== 1 || busy !== 1'b1 || n_done !== 0) begin
      n_bad++;
      $display("FAIL abort_pulse got aborts %0d busy %b done %0d want 1 1 0",
               n_abort, busy, n_done);
    end
    n_cmp++;
    if (black_level !== 12'd100) begin
      n_bad++; $display("FAIL abort_black_kept got %0d want 100", black_level);
    end
    pixels(32, 12'd200);
    n_cmp++;
    if (black_level !== 12'd200) begin
      n_bad++; $display("FAIL abort_restart_black got %0d want 200", black_level);
    end
    pixels(3648, 12'd700);
    pixels(14, 12'd0);
    repeat (10) @(posedge clk); #1;
    bad = 0;
    foreach (q_data[i]) if (q_data[i] !== ((i < 40) ? 12'd50 : 12'd500)) bad++;
    n_cmp++;
    if (q_data.size() !== 3688 || bad !== 0) begin
      n_bad++;
      $display("FAIL abort_drain got %0d samples %0d wrong want 3688 samples 0 wrong",
               q_data.size(), bad);
    end
    n_cmp++;
    if (q_first.size() < 41 || q_first[0] !== 1'b1 || q_first[40] !== 1'b1 || n_done !== 1) begin
      n_bad++; $display("FAIL abort_tags got done %0d want firsts at 0,40 and done 1", n_done);
    end
  endtask

  task automatic test_held();
    clear_q(); out_ready = 1'b1;
    sh_pulse();
    @(posedge clk); #1 adc_data = 12'd100; pixel_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 pixel_ready = 1'b0;
    pixels(31, 12'd100);
    @(posedge clk); #1 adc_data = 12'd400; pixel_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 pixel_ready = 1'b0;
    repeat (5) @(posedge clk); #1;
    n_cmp++;
    if (q_data.size() !== 1) begin
      n_bad++; $display("FAIL held_count got %0d want 1", q_data.size());
    end else begin
      n_cmp++;
      if (q_data[0] !== 12'd300 || q_first[0] !== 1'b1) begin
        n_bad++; $display("FAIL held_data got %0d/%b want 300/1", q_data[0], q_first[0]);
      end
    end
  endtask

  task automatic test_rst_mid();
    int ab;
    out_ready = 1'b0;
    pix(12'd500);
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 12'd400 || busy !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre got v %b data %0d busy %b want 1 400 1",
                        out_valid, out_data, busy);
    end
    ab = n_abort;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, out_first, out_last, busy, line_done, overflow, aborted} !== 7'b0 ||
        out_data !== 12'd0 || black_level !== 12'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs got flags %b data %0d black %0d want 0",
               {out_valid, out_first, out_last, busy, line_done, overflow, aborted},
               out_data, black_level);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (n_abort !== ab || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_after got aborts %0d busy %b valid %b want %0d 0 0",
                        n_abort, busy, out_valid, ab);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underflow();
    test_overflow();
    test_abort();
    test_held();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccd_pixel_capture.md
CCD_PIXEL_CAPTURE -- requirements
Module: ccd_pixel_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 12, ADC sample width.
REQ-002 SHALL have parameter LEAD_DUMMY, default 32, dummy pixels before active region.
REQ-003 SHALL have parameter ACTIVE_PIX, default 3648, active pixels per line.
REQ-004 SHALL have parameter TRAIL_DUMMY, default 14, dummy pixels after active region.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, output buffer entries (power of two).
REQ-006 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: SH  in  1  shift gate from ccd_driver; rising edge starts a line.
REQ-009 SHALL have ports: pixel_ready  in  1  from ccd_driver; rising edge marks a valid ADC sample.
REQ-010 SHALL have ports: adc_data  in  DATA_W  external ADC parallel bus.
REQ-011 SHALL have ports: out_ready  in  1  consumer accept.
REQ-012 SHALL have ports: out_valid  out  1, out_data  out  DATA_W, out_first  out  1, out_last  out  1.
REQ-013 SHALL have ports: black_level  out  DATA_W  current dark estimate.
REQ-014 SHALL have ports: busy  out  1, line_done  out  1 (pulse), overflow  out  1 (sticky), aborted  out  1 (pulse).

Function
REQ-015 SHALL detect edges of SH and pixel_ready with one register each; a held level counts once.
REQ-016 SHALL implement FSM IDLE, DUMMY, ACTIVE, TRAIL; busy high in all states except IDLE.
REQ-017 SHALL move IDLE->DUMMY on SH rising edge, clearing pixel counter, dark accumulator, and overflow.
REQ-018 SHALL count pixel_ready edges per state; DUMMY->ACTIVE after LEAD_DUMMY, ACTIVE->TRAIL after ACTIVE_PIX, TRAIL->IDLE after TRAIL_DUMMY.
REQ-019 SHALL pulse line_done for one cycle on the TRAIL->IDLE transition.
REQ-020 SHALL sum dummy samples with indices LEAD_DUMMY-16 to LEAD_DUMMY-1 in a DATA_W+4 bit accumulator.
REQ-021 SHALL load black_level with sum>>4 on the DUMMY->ACTIVE transition; black_level resets to 0.
REQ-022 SHALL compute each active output as adc_data minus black_level, clamped to 0 on underflow.
REQ-023 SHALL register the corrected sample one cycle after the pixel_ready edge and write it to the FIFO the following cycle; out_valid is high 2 cycles after the edge when the FIFO was empty.
REQ-024 SHALL tag the first active pixel with out_first and the last with out_last, stored per FIFO entry.
REQ-025 SHALL drop an active sample when the FIFO is full and not popped that cycle, and set overflow until the next line start or reset.
REQ-026 SHALL accept a push to a full FIFO when a pop (out_valid and out_ready) occurs in the same cycle.
REQ-027 SHALL hold out_data, out_first, and out_last stable while out_valid is high and out_ready is low.
REQ-028 SHALL treat an SH rising edge outside IDLE as a restart: pulse aborted, enter DUMMY, keep FIFO contents.
REQ-029 SHALL ignore pixel_ready edges in IDLE and discard samples in DUMMY and TRAIL apart from dark accumulation.

Reset
REQ-030 SHALL, on rst, set the FSM to IDLE and empty the FIFO.
REQ-031 SHALL, on rst, drive out_valid, out_first, out_last, busy, line_done, overflow, aborted, out_data, and black_level to 0.
REQ-032 SHALL let rst mid-line discard the line without an aborted pulse.

Structure
REQ-033 SHALL take the FSM state enum and default line geometry constants from a shared package, ccd_pkg.
REQ-034 SHALL implement the FIFO as sub-module ccd_sample_fifo: DATA_W+2 bits wide, synchronous, registered outputs, with full and empty flags.

Verification
REQ-035 SHALL cover: SH pulse, 3694 pixel_ready pulses, dummies=100, actives=600, out_ready=1 -> black_level=100, 3648 outputs of 500, first/last tagged, one line_done.
REQ-036 SHALL cover: actives=50 with black_level=100 -> every out_data=0.
REQ-037 SHALL cover: out_ready=0 for the whole line -> 16 entries held, overflow=1, out_data stable.
REQ-038 SHALL cover: second SH edge after 40 actives -> aborted pulse, restart in DUMMY, the 40 earlier samples still drained.
REQ-039 SHALL cover: pixel_ready held high 10 cycles -> exactly one sample counted.
REQ-040 SHALL cover: rst asserted in ACTIVE -> next cycle all outputs 0, FSM IDLE, no aborted pulse.
